// File: rtl/epochtv1_pkg.sv
// epochtv1_pkg: TV-1 timing constants and layer pixel types shared by the
// background and sprite paths.
package epochtv1_pkg;
   localparam logic [8:0] NUM_ROWS         = 9'd263;
   localparam logic [8:0] NUM_COLS         = 9'd260;
   localparam logic [8:0] FIRST_ROW_RENDER = 9'd21;
   localparam logic [8:0] LAST_ROW_RENDER  = 9'd242;
   localparam logic [8:0] FIRST_COL_RENDER = 9'd28;
   localparam logic [8:0] LAST_COL_RENDER  = 9'd219;
   localparam logic [8:0] PRE_RENDER_ROW   = 9'd20;
   typedef logic [3:0] t_clr;
   typedef struct packed {
      logic opaque;
      t_clr color;
   } s_layer_px;
   typedef enum logic {ST_IDLE, ST_FETCH} t_fetch_st;
endpackage

// File: rtl/epochtv1_bg_if.sv
// epochtv1_bg_if: video timing, colour registers, BGM/CHR read ports and the
// background pixel stream of the TV-1 background layer.
interface epochtv1_bg_if;
   import epochtv1_pkg::*;
   logic       CE;
   logic [8:0] ROW;
   logic [8:0] COL;
   t_clr       FG_CLR;
   t_clr       BG_CLR;
   logic [8:0] BGM_A;
   logic [7:0] BGM_D;
   logic [9:0] CHR_A;
   logic [7:0] CHR_D;
   s_layer_px  BG_PX;
   modport master (output CE, ROW, COL, FG_CLR, BG_CLR, BGM_D, CHR_D,
                   input BGM_A, CHR_A, BG_PX);
   modport slave  (input CE, ROW, COL, FG_CLR, BG_CLR, BGM_D, CHR_D,
                   output BGM_A, CHR_A, BG_PX);
endinterface

// File: rtl/epochtv1_bg.sv
// epochtv1_bg: fetches BGM codes and CHR patterns one cell ahead and serialises
// them MSB-first into a registered {opaque, color} background pixel stream.
module epochtv1_bg
   import epochtv1_pkg::*;
#(
   parameter logic [8:0] FIRST_ROW_RENDER = 9'd21,
   parameter logic [8:0] NUM_RENDER_ROWS  = 9'd222,
   parameter logic [8:0] FIRST_COL_RENDER = 9'd28,
   parameter logic [4:0] NUM_CELLS        = 5'd24
) (
   input logic           CLK,
   input logic           RST,
   epochtv1_bg_if.slave  b
);
   t_fetch_st  st_q;
   logic [4:0] k_q;
   logic [2:0] p_q;
   logic [7:0] code_q, pend_q, shf_q;
   logic [8:0] bgm_a_q;
   logic [9:0] chr_a_q;
   s_layer_px  px_q;
   logic       lv_q;
   logic [8:0] r;
   logic [2:0] ph;
   logic [4:0] kk;
   logic       act, go, run, win;
   // The entry edge is itself phase 0, so p_q holds the phase of the next edge.
   always_comb begin
      r = b.ROW - FIRST_ROW_RENDER;
      act = b.ROW >= FIRST_ROW_RENDER && r < NUM_RENDER_ROWS;
      go = st_q == ST_IDLE && act && b.COL == FIRST_COL_RENDER - 9'd8;
      run = act && (go || st_q == ST_FETCH);
      ph = go ? 3'd0 : p_q;
      kk = go ? 5'd0 : k_q;
      win = act && lv_q && b.COL >= FIRST_COL_RENDER
            && b.COL <= FIRST_COL_RENDER + {1'b0, NUM_CELLS, 3'b000} - 9'd1;
   end
   // lv_q marks a line whose fetch started at the proper column; a reset
   // mid-line clears it so the remainder of that line stays blank.
   always_ff @(posedge CLK)
      if (RST) begin
         st_q <= ST_IDLE;
         k_q <= '0;
         p_q <= '0;
         code_q <= '0;
         pend_q <= '0;
         shf_q <= '0;
         bgm_a_q <= '0;
         chr_a_q <= '0;
         px_q <= '0;
         lv_q <= 1'b0;
      end else if (b.CE) begin
         px_q <= win ? (shf_q[7] ? {1'b1, b.FG_CLR} : {1'b0, b.BG_CLR}) : 5'd0;
         if (win) shf_q <= {shf_q[6:0], 1'b0};
         if (!act) begin
            st_q <= ST_IDLE;
            lv_q <= 1'b0;
         end else if (go) lv_q <= 1'b1;
         if (run) begin
            p_q <= ph + 3'd1;
            if (go) begin
               st_q <= ST_FETCH;
               k_q <= 5'd0;
            end
            if (ph == 3'd0) bgm_a_q <= {r[7:4], kk};
            if (ph == 3'd1) code_q <= b.BGM_D;
            if (ph == 3'd2) chr_a_q <= {code_q[6:0], r[3:1]};
            if (ph == 3'd3) pend_q <= b.CHR_D ^ {8{code_q[7]}};
            if (ph == 3'd7) begin
               shf_q <= pend_q;
               k_q <= k_q + 5'd1;
               if (k_q == NUM_CELLS - 5'd1) st_q <= ST_IDLE;
            end
         end
      end
   assign b.BGM_A = bgm_a_q;
   assign b.CHR_A = chr_a_q;
   assign b.BG_PX = px_q;
endmodule

// File: tb/tb_epochtv1_bg.sv
// tb_epochtv1_bg: random and directed rows against a per-pixel model that looks
// the picture up directly from the map and character arrays.
module tb_epochtv1_bg;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   epochtv1_bg_if b();
   epochtv1_bg dut (.CLK(clk), .RST(rst), .b(b));
   logic [7:0] bgm [512];
   logic [7:0] chr [1024];
   assign b.BGM_D = bgm[b.BGM_A];
   assign b.CHR_D = chr[b.CHR_A];
   logic [4:0] obs [260];
   logic [4:0] ref_obs [260];
   logic [8:0] bga [260];
   logic [3:0] fgs [260];
   logic [3:0] bgs [260];
   int vec = 0;
   int errs = 0;
   int hold_bad = 0;
   function automatic logic [4:0] model_px(input int row, input int c, input logic [3:0] fg, input logic [3:0] bg);
      int r, x;
      logic [7:0] code, pat;
      r = row - 21;
      x = c - 28;
      if (r < 0 || r >= 222 || x < 0 || x >= 192) return 5'd0;
      code = bgm[9'((r / 16) * 32 + x / 8)];
      pat = chr[10'(int'(code & 8'h7f) * 8 + (r % 16) / 2)] ^ {8{code[7]}};
      return pat[3'(7 - x % 8)] ? {1'b1, fg} : {1'b0, bg};
   endfunction
   task automatic fill_rand();
      for (int i = 0; i < 512; i++) bgm[i] = 8'($urandom);
      for (int i = 0; i < 1024; i++) chr[i] = 8'($urandom);
   endtask
   // obs[c] is the pixel registered at the CE edge where COL == c.
   task automatic run_row(input int row, input bit rclr, input bit half, input int rst_col);
      logic [4:0] p0;
      logic [8:0] a0;
      logic [9:0] c0;
      for (int c = 0; c < 260; c++) begin
         b.ROW = 9'(row);
         b.COL = 9'(c);
         if (rclr) begin
            b.FG_CLR = 4'($urandom);
            b.BG_CLR = 4'($urandom);
         end
         fgs[c] = b.FG_CLR;
         bgs[c] = b.BG_CLR;
         rst = 1'b0;
         if (half && $urandom_range(1, 0) == 1) begin
            b.CE = 1'b0;
            p0 = b.BG_PX;
            a0 = b.BGM_A;
            c0 = b.CHR_A;
            @(posedge clk); #1;
            if (b.BG_PX !== p0 || b.BGM_A !== a0 || b.CHR_A !== c0) hold_bad++;
         end
         rst = (c == rst_col);
         b.CE = 1'b1;
         @(posedge clk); #1;
         obs[c] = b.BG_PX;
         bga[c] = b.BGM_A;
      end
      rst = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      b.CE = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      vec++;
      if ({b.BG_PX, b.BGM_A, b.CHR_A} !== 24'd0) begin
         errs++;
         $display("FAIL reset: px=%h bgm_a=%h chr_a=%h, need all 0", b.BG_PX, b.BGM_A, b.CHR_A);
      end
   endtask
   task automatic test_pattern();
      logic [4:0] want [8];
      logic [4:0] inv [8];
      logic [4:0] r23 [8];
      want = '{5'h1F, 5'h02, 5'h1F, 5'h02, 5'h02, 5'h1F, 5'h02, 5'h1F};
      inv  = '{5'h02, 5'h1F, 5'h02, 5'h1F, 5'h1F, 5'h02, 5'h1F, 5'h02};
      r23  = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h02, 5'h02, 5'h02, 5'h02};
      fill_rand();
      bgm[0] = 8'h01;
      for (int i = 8; i < 16; i++) chr[i] = 8'hA5;
      chr[9] = 8'h0F;
      b.FG_CLR = 4'hF;
      b.BG_CLR = 4'h2;
      run_row(21, 1'b0, 1'b0, -1);
      for (int i = 0; i < 8; i++) begin
         vec++;
         if (obs[28 + i] !== want[i]) begin
            errs++;
            $display("FAIL pattern_a5 col %0d: got %h want %h", 29 + i, obs[28 + i], want[i]);
         end
      end
      bgm[0] = 8'h81;
      run_row(21, 1'b0, 1'b0, -1);
      ref_obs = obs;
      for (int i = 0; i < 8; i++) begin
         vec++;
         if (obs[28 + i] !== inv[i]) begin
            errs++;
            $display("FAIL pattern_inv col %0d: got %h want %h", 29 + i, obs[28 + i], inv[i]);
         end
      end
      run_row(22, 1'b0, 1'b0, -1);
      for (int c = 0; c < 260; c++) begin
         vec++;
         if (obs[c] !== ref_obs[c]) begin
            errs++;
            $display("FAIL row22_repeat col %0d: got %h want %h", c, obs[c], ref_obs[c]);
         end
      end
      run_row(23, 1'b0, 1'b0, -1);
      for (int i = 0; i < 8; i++) begin
         vec++;
         if (obs[28 + i] !== r23[i]) begin
            errs++;
            $display("FAIL row23_line1 col %0d: got %h want %h", 29 + i, obs[28 + i], r23[i]);
         end
      end
   endtask
   task automatic test_last_row();
      fill_rand();
      for (int k = 0; k < 24; k++) bgm[13 * 32 + k] = 8'(k);
      run_row(21 + 16 * 13, 1'b1, 1'b0, -1);
      for (int k = 0; k < 24; k++) begin
         vec++;
         if (bga[20 + 8 * k] !== {4'd13, 5'(k)}) begin
            errs++;
            $display("FAIL last_row_bgm_a k=%0d: got %h want %h", k, bga[20 + 8 * k], {4'd13, 5'(k)});
         end
      end
      for (int c = 0; c < 260; c++) begin
         vec++;
         if (obs[c] !== model_px(21 + 16 * 13, c, fgs[c], bgs[c])) begin
            errs++;
            $display("FAIL last_row_px col %0d: got %h want %h", c + 1, obs[c], model_px(21 + 16 * 13, c, fgs[c], bgs[c]));
         end
      end
      vec++;
      if (obs[27] !== 5'd0 || obs[220] !== 5'd0) begin
         errs++;
         $display("FAIL last_row_edges: col28 %h col221 %h, need 0", obs[27], obs[220]);
      end
   endtask
   task automatic test_idle_rows();
      logic [8:0] a0;
      logic [9:0] c0;
      int rows [2];
      rows = '{20, 243};
      fill_rand();
      a0 = b.BGM_A;
      c0 = b.CHR_A;
      foreach (rows[j]) begin
         run_row(rows[j], 1'b1, 1'b0, -1);
         for (int c = 0; c < 260; c++) begin
            vec++;
            if (obs[c] !== 5'd0 || bga[c] !== a0) begin
               errs++;
               $display("FAIL idle_row %0d col %0d: px %h bgm_a %h, want 0 and %h", rows[j], c, obs[c], bga[c], a0);
            end
         end
      end
      vec++;
      if (b.CHR_A !== c0) begin
         errs++;
         $display("FAIL idle_chr_a: got %h want %h", b.CHR_A, c0);
      end
   endtask
   task automatic test_mid_reset();
      logic [4:0] e;
      fill_rand();
      run_row(30, 1'b1, 1'b0, 100);
      for (int c = 0; c < 260; c++) begin
         e = (c >= 100) ? 5'd0 : model_px(30, c, fgs[c], bgs[c]);
         vec++;
         if (obs[c] !== e) begin
            errs++;
            $display("FAIL mid_reset row30 col %0d: got %h want %h", c + 1, obs[c], e);
         end
      end
      run_row(31, 1'b1, 1'b0, -1);
      for (int c = 0; c < 260; c++) begin
         vec++;
         if (obs[c] !== model_px(31, c, fgs[c], bgs[c])) begin
            errs++;
            $display("FAIL after_reset row31 col %0d: got %h want %h", c + 1, obs[c], model_px(31, c, fgs[c], bgs[c]));
         end
      end
   endtask
   task automatic test_ce_toggle();
      fill_rand();
      b.FG_CLR = 4'h9;
      b.BG_CLR = 4'h4;
      run_row(40, 1'b0, 1'b0, -1);
      ref_obs = obs;
      hold_bad = 0;
      run_row(40, 1'b0, 1'b1, -1);
      for (int c = 0; c < 260; c++) begin
         vec++;
         if (obs[c] !== ref_obs[c] || obs[c] !== model_px(40, c, 4'h9, 4'h4)) begin
            errs++;
            $display("FAIL ce_toggle col %0d: got %h want %h", c + 1, obs[c], model_px(40, c, 4'h9, 4'h4));
         end
      end
      vec++;
      if (hold_bad !== 0) begin
         errs++;
         $display("FAIL ce_low_hold: %0d cycles changed state, want 0", hold_bad);
      end
   endtask
   task automatic test_random();
      int row;
      for (int n = 0; n < 8; n++) begin
         fill_rand();
         row = (n == 0) ? 242 : int'($urandom_range(242, 21));
         run_row(row, 1'b1, 1'b0, -1);
         for (int c = 0; c < 260; c++) begin
            vec++;
            if (obs[c] !== model_px(row, c, fgs[c], bgs[c])) begin
               errs++;
               $display("FAIL random row %0d col %0d: got %h want %h", row, c + 1, obs[c], model_px(row, c, fgs[c], bgs[c]));
            end
         end
      end
   endtask
   initial begin
      rst = 1'b1;
      b.CE = 1'b0;
      b.ROW = '0;
      b.COL = '0;
      b.FG_CLR = '0;
      b.BG_CLR = '0;
      for (int i = 0; i < 512; i++) bgm[i] = '0;
      for (int i = 0; i < 1024; i++) chr[i] = '0;
      test_reset();
      test_pattern();
      test_last_row();
      test_idle_rows();
      test_mid_reset();
      test_ce_toggle();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
